// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin grant arbiter.
// Holds the FSM state encoding and the rotate/priority-select pick function.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } arb_state_e;

   // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [N_REQ-1:0]   sel;
      dbl = {req, req} >> ptr;
      rot = dbl[N_REQ-1:0];
      sel = rot & (-rot);
      dbl = {sel, sel} << ptr;
      return dbl[2*N_REQ-1:N_REQ];
   endfunction

endpackage

// File: rtl/rr_grant_arbiter4_if.sv
// Request/grant bundle between requester blocks and the round-robin arbiter.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface rr_grant_arbiter4_if;
   import arb_pkg::*;

   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             preempt;

   modport master (
      output en,
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  preempt
   );

   modport slave (
      input  en,
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output preempt
   );

endinterface

// File: rtl/grant_encoder42.sv
// Combinational one-hot(4) to binary(2) encoder with a valid flag.
// Non-one-hot inputs (including zero) encode to index 0.
module grant_encoder42
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] onehot_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = |onehot_i;
      unique case (onehot_i)
         4'b0001: idx_o = 2'd0;
         4'b0010: idx_o = 2'd1;
         4'b0100: idx_o = 2'd2;
         4'b1000: idx_o = 2'd3;
         default: idx_o = 2'd0;
      endcase
   end

endmodule

// File: rtl/rr_grant_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, binary index,
// and an optional hold timeout that preempts an owner while others are waiting.
module rr_grant_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   rr_grant_arbiter4_if.slave  bus
);

   if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for MAX_HOLD");
   end

   localparam bit               TimeoutEn = (MAX_HOLD != 0);
   localparam int unsigned      HoldLastI = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HoldLastI);
   localparam logic [CNT_W-1:0] HoldMax   = CNT_W'(MAX_HOLD);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             preempt_q, preempt_d;

   logic [N_REQ-1:0] pick;
   logic [N_REQ-1:0] others;
   logic             owner_req;
   logic             issue;

   assign pick      = rr_pick(bus.req, ptr_q);
   assign others    = bus.req & ~gnt_q;
   assign owner_req = |(bus.req & gnt_q);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      preempt_d  = 1'b0;
      issue      = 1'b0;
      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (bus.en && (|bus.req)) begin
               issue      = 1'b1;
               gnt_d      = pick;
               hold_cnt_d = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            // Release is checked first so it wins over a coincident timeout.
            if (!owner_req) begin
               gnt_d   = '0;
               state_d = StIdle;
            end else if (TimeoutEn && (hold_cnt_q == HoldLast) && (|others)) begin
               gnt_d     = '0;
               preempt_d = 1'b1;
               state_d   = StIdle;
            end else if (hold_cnt_q != HoldMax) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   grant_encoder42 u_enc (
      .onehot_i (gnt_d),
      .idx_o    (gnt_idx_d),
      .valid_o  (gnt_valid_d)
   );

   // Kept apart from the FSM block so the encoder feedback is not a block-level loop.
   always_comb begin
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = gnt_idx_d + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Self-checking bench for rr_grant_arbiter4 with MAX_HOLD=4: a vector table driven
// through a scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_rr_grant_arbiter4;
   import arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   rr_grant_arbiter4_if bus ();

   rr_grant_arbiter4 #(
      .MAX_HOLD (4),
      .CNT_W    (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       en;
      logic [3:0] req;
      logic [3:0] gnt;
      logic       pre;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic       pre;
      int         id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) begin
         if (g[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   task automatic check_out(input string nm, input logic [3:0] eg, input logic ep);
      logic [7:0] act;
      logic [7:0] req_v;
      act   = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt};
      req_v = {eg, idx_of(eg), (eg != 4'b0000), ep};
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got gnt=%b idx=%0d valid=%b preempt=%b, want gnt=%b idx=%0d valid=%b preempt=%b",
                  nm, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt,
                  eg, idx_of(eg), (eg != 4'b0000), ep);
      end
   endtask

   task automatic add(input logic e, input logic [3:0] r, input logic [3:0] g, input logic p);
      vec_t v;
      v.en  = e;
      v.req = r;
      v.gnt = g;
      v.pre = p;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs; the expected registered response is queued and
   // popped once the DUT has clocked it out.
   task automatic step(input vec_t v, input int id);
      exp_t x;
      bus.en  = v.en;
      bus.req = v.req;
      x.gnt   = v.gnt;
      x.pre   = v.pre;
      x.id    = id;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check_out($sformatf("vec%0d", x.id), x.gnt, x.pre);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      vec_t       v;

      rst_n   = 1'b0;
      bus.en  = 1'b1;
      bus.req = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset_hold", 4'b0000, 1'b0);
      rst_n = 1'b1;

      // Rotation 0,1,2,3,0: three granted cycles then a one-cycle drop.
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         for (int j = 0; j < 3; j++) add(1'b1, 4'b1111, g, 1'b0);
         add(1'b1, 4'b1111 & ~g, 4'b0000, 1'b0);
      end

      // Fairness skip from ptr=1, then from ptr=0.
      add(1'b1, 4'b1001, 4'b1000, 1'b0);
      add(1'b1, 4'b0001, 4'b0000, 1'b0);
      add(1'b1, 4'b1001, 4'b0001, 1'b0);
      add(1'b1, 4'b0000, 4'b0000, 1'b0);
      add(1'b1, 4'b1000, 4'b1000, 1'b0);
      add(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Timeout: owner 0 held four cycles, preempted, then requester 1 wins.
      for (int j = 0; j < 4; j++) add(1'b1, 4'b0011, 4'b0001, 1'b0);
      add(1'b1, 4'b0011, 4'b0000, 1'b1);
      add(1'b1, 4'b0011, 4'b0010, 1'b0);
      add(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Release coincides with timeout: no preempt.
      for (int j = 0; j < 4; j++) add(1'b1, 4'b0110, 4'b0100, 1'b0);
      add(1'b1, 4'b0010, 4'b0000, 1'b0);
      add(1'b1, 4'b0000, 4'b0000, 1'b0);

      // No contender: grant held 20 cycles with no preempt.
      for (int j = 0; j < 20; j++) add(1'b1, 4'b0100, 4'b0100, 1'b0);
      add(1'b1, 4'b0000, 4'b0000, 1'b0);

      // Enable low during BUSY, then blocks new grants until raised.
      add(1'b1, 4'b0010, 4'b0010, 1'b0);
      add(1'b0, 4'b0010, 4'b0010, 1'b0);
      add(1'b0, 4'b0010, 4'b0010, 1'b0);
      add(1'b0, 4'b0000, 4'b0000, 1'b0);
      add(1'b0, 4'b0010, 4'b0000, 1'b0);
      add(1'b0, 4'b0010, 4'b0000, 1'b0);
      add(1'b1, 4'b0010, 4'b0010, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], i);
      end

      // Asynchronous reset in the middle of a grant (owner 1, ptr=2).
      v = '{en: 1'b1, req: 4'b0010, gnt: 4'b0010, pre: 1'b0};
      step(v, 900);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_held", 4'b0000, 1'b0);
      bus.req = 4'b1111;
      rst_n   = 1'b1;
      v = '{en: 1'b1, req: 4'b1111, gnt: 4'b0001, pre: 1'b0};
      step(v, 901);
      v = '{en: 1'b1, req: 4'b1110, gnt: 4'b0000, pre: 1'b0};
      step(v, 902);
      v = '{en: 1'b1, req: 4'b1111, gnt: 4'b0010, pre: 1'b0};
      step(v, 903);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
